// File: rtl/iir_biquad_sequencer.sv
// Sample sequencer and feedback owner for the biquad IIR lowpass filter.
// Issues x(n) with y(n-1)/y(n-2), captures the result, and owns the coefficient bank.
module iir_biquad_sequencer #(
   parameter int unsigned TIMEOUT   = 16,
   parameter int          B1_RST    = 65536,
   parameter int unsigned SHIFT_RST = 16
) (
   input  logic        clk,
   input  logic        i_rst,
   input  logic        i_sample_valid,
   input  logic [15:0] i_sample,
   output logic        o_sample_ready,
   output logic        o_flt_valid,
   output logic [15:0] o_flt_x,
   output logic [15:0] o_flt_y1,
   output logic [15:0] o_flt_y2,
   input  logic        i_flt_valid,
   input  logic [15:0] i_flt_y,
   output logic        o_out_valid,
   output logic [15:0] o_out_sample,
   input  logic        i_out_ready,
   input  logic        i_coef_we,
   input  logic [2:0]  i_coef_addr,
   input  logic [17:0] i_coef_data,
   input  logic        i_coef_commit,
   input  logic        i_flush,
   output logic [17:0] o_b1,
   output logic [17:0] o_b2,
   output logic [17:0] o_b3,
   output logic [17:0] o_a2,
   output logic [17:0] o_a3,
   output logic [6:0]  o_shift,
   output logic        o_timeout,
   output logic [15:0] o_sample_cnt
);

   localparam int unsigned DW    = 16;
   localparam int unsigned CW    = 18;
   localparam int unsigned SW    = 7;
   localparam int unsigned NCOEF = 5;
   localparam int unsigned TW    = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_OUTPUT
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_accept;
   logic            w_capture;
   logic            w_expire;
   logic            w_handshake;
   logic            w_flush;
   logic            w_commit;

   logic [TW-1:0]   r_wait_cnt;
   logic            r_sample_ready;
   logic            r_flt_valid;
   logic            r_out_valid;
   logic [DW-1:0]   r_x;
   logic [DW-1:0]   r_flt_y1;
   logic [DW-1:0]   r_flt_y2;
   logic [DW-1:0]   r_y1;
   logic [DW-1:0]   r_y2;
   logic [DW-1:0]   r_out_sample;
   logic [DW-1:0]   r_sample_cnt;
   logic            r_timeout;
   logic            r_flush_pend;
   logic            r_commit_pend;

   logic [CW-1:0]   r_shd_coef [NCOEF];
   logic [CW-1:0]   r_act_coef [NCOEF];
   logic [CW-1:0]   w_shd_coef_nxt [NCOEF];
   logic [SW-1:0]   r_shd_shift;
   logic [SW-1:0]   r_act_shift;
   logic [SW-1:0]   w_shd_shift_nxt;

   // State register
   always_ff @(posedge clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and per-cycle event decode
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_expire    = 1'b0;
      w_handshake = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_sample_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (i_flt_valid) begin
               w_capture   = 1'b1;
               w_state_nxt = S_OUTPUT;
            end else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
               w_expire    = 1'b1;
               w_state_nxt = S_OUTPUT;
            end
         end
         S_OUTPUT: begin
            if (i_out_ready) begin
               w_handshake = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // A flush or commit raised this cycle counts as already pending
   assign w_flush  = r_flush_pend  | i_flush;
   assign w_commit = r_commit_pend | i_coef_commit;

   // Sample datapath, history and status
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_wait_cnt     <= '0;
         r_sample_ready <= 1'b1;
         r_flt_valid    <= 1'b0;
         r_out_valid    <= 1'b0;
         r_x            <= '0;
         r_flt_y1       <= '0;
         r_flt_y2       <= '0;
         r_y1           <= '0;
         r_y2           <= '0;
         r_out_sample   <= '0;
         r_sample_cnt   <= '0;
         r_timeout      <= 1'b0;
         r_flush_pend   <= 1'b0;
      end else begin
         r_sample_ready <= (w_state_nxt == S_IDLE);
         r_flt_valid    <= (w_state_nxt == S_ISSUE);
         r_out_valid    <= (w_state_nxt == S_OUTPUT);

         if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + TW'(1);
         else                   r_wait_cnt <= '0;

         if (r_state == S_IDLE)  r_flush_pend <= 1'b0;
         else if (i_flush)       r_flush_pend <= 1'b1;

         if (r_state == S_IDLE && w_flush) begin
            r_y1 <= '0;
            r_y2 <= '0;
         end

         if (w_accept) begin
            r_x      <= i_sample;
            r_flt_y1 <= w_flush ? '0 : r_y1;
            r_flt_y2 <= w_flush ? '0 : r_y2;
         end

         if (w_capture) begin
            r_y2         <= r_y1;
            r_y1         <= i_flt_y;
            r_out_sample <= i_flt_y;
         end

         if (w_expire) begin
            r_timeout    <= 1'b1;
            r_out_sample <= '0;
         end

         if (w_handshake) r_sample_cnt <= r_sample_cnt + DW'(1);
      end
   end

   // Shadow bank after this cycle's write, so a same-cycle commit sees it
   always_comb begin
      for (int i = 0; i < int'(NCOEF); i++) begin
         w_shd_coef_nxt[i] = r_shd_coef[i];
         if (i_coef_we && i_coef_addr == 3'(i)) w_shd_coef_nxt[i] = i_coef_data;
      end
      w_shd_shift_nxt = r_shd_shift;
      if (i_coef_we && i_coef_addr == 3'd5) w_shd_shift_nxt = i_coef_data[SW-1:0];
   end

   // Shadow and active coefficient banks; active only moves while IDLE
   always_ff @(posedge clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(NCOEF); i++) begin
            r_shd_coef[i] <= (i == 0) ? CW'(B1_RST) : '0;
            r_act_coef[i] <= (i == 0) ? CW'(B1_RST) : '0;
         end
         r_shd_shift   <= SW'(SHIFT_RST);
         r_act_shift   <= SW'(SHIFT_RST);
         r_commit_pend <= 1'b0;
      end else begin
         for (int i = 0; i < int'(NCOEF); i++) r_shd_coef[i] <= w_shd_coef_nxt[i];
         r_shd_shift <= w_shd_shift_nxt;

         if (r_state == S_IDLE) r_commit_pend <= 1'b0;
         else if (i_coef_commit) r_commit_pend <= 1'b1;

         if (r_state == S_IDLE && w_commit) begin
            for (int i = 0; i < int'(NCOEF); i++) r_act_coef[i] <= w_shd_coef_nxt[i];
            r_act_shift <= w_shd_shift_nxt;
         end
      end
   end

   assign o_sample_ready = r_sample_ready;
   assign o_flt_valid    = r_flt_valid;
   assign o_flt_x        = r_x;
   assign o_flt_y1       = r_flt_y1;
   assign o_flt_y2       = r_flt_y2;
   assign o_out_valid    = r_out_valid;
   assign o_out_sample   = r_out_sample;
   assign o_b1           = r_act_coef[0];
   assign o_b2           = r_act_coef[1];
   assign o_b3           = r_act_coef[2];
   assign o_a2           = r_act_coef[3];
   assign o_a3           = r_act_coef[4];
   assign o_shift        = r_act_shift;
   assign o_timeout      = r_timeout;
   assign o_sample_cnt   = r_sample_cnt;

endmodule

// File: tb/tb_iir_biquad_sequencer.sv
// Self-checking bench for iir_biquad_sequencer: vector table, scoreboard and corner sequences.
module tb_iir_biquad_sequencer;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_sample_valid;
   logic [15:0] i_sample;
   logic        o_sample_ready;
   logic        o_flt_valid;
   logic [15:0] o_flt_x;
   logic [15:0] o_flt_y1;
   logic [15:0] o_flt_y2;
   logic        i_flt_valid;
   logic [15:0] i_flt_y;
   logic        o_out_valid;
   logic [15:0] o_out_sample;
   logic        i_out_ready;
   logic        i_coef_we;
   logic [2:0]  i_coef_addr;
   logic [17:0] i_coef_data;
   logic        i_coef_commit;
   logic        i_flush;
   logic [17:0] o_b1, o_b2, o_b3, o_a2, o_a3;
   logic [6:0]  o_shift;
   logic        o_timeout;
   logic [15:0] o_sample_cnt;

   always #5 clk = ~clk;

   iir_biquad_sequencer #(.TIMEOUT(16), .B1_RST(65536), .SHIFT_RST(16)) dut (
      .clk(clk), .i_rst(i_rst),
      .i_sample_valid(i_sample_valid), .i_sample(i_sample), .o_sample_ready(o_sample_ready),
      .o_flt_valid(o_flt_valid), .o_flt_x(o_flt_x), .o_flt_y1(o_flt_y1), .o_flt_y2(o_flt_y2),
      .i_flt_valid(i_flt_valid), .i_flt_y(i_flt_y),
      .o_out_valid(o_out_valid), .o_out_sample(o_out_sample), .i_out_ready(i_out_ready),
      .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
      .i_coef_commit(i_coef_commit), .i_flush(i_flush),
      .o_b1(o_b1), .o_b2(o_b2), .o_b3(o_b3), .o_a2(o_a2), .o_a3(o_a3), .o_shift(o_shift),
      .o_timeout(o_timeout), .o_sample_cnt(o_sample_cnt)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_q[$];
   logic [15:0] sb_exp;
   logic [15:0] fx;
   int unsigned flt_delay  = 1;
   bit          flt_silent = 1'b0;

   typedef struct {
      logic [15:0] x;
      int unsigned k;
      logic [15:0] ey1;
      logic [15:0] ey2;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Passthrough filter model: answers x after flt_delay cycles unless silenced
   initial begin
      i_flt_valid = 1'b0;
      i_flt_y     = '0;
      forever begin
         @(posedge clk); #1;
         if (o_flt_valid && !flt_silent) begin
            fx = o_flt_x;
            repeat (flt_delay) @(posedge clk);
            #1;
            i_flt_valid = 1'b1;
            i_flt_y     = fx;
            @(posedge clk); #1;
            i_flt_valid = 1'b0;
         end
      end
   end

   // Scoreboard: compare each downstream handshake against the queue
   initial begin
      forever begin
         @(negedge clk);
         if (!i_rst && o_out_valid && i_out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL scoreboard: unexpected output %0h", o_out_sample);
            end else begin
               sb_exp = exp_q.pop_front();
               check("scoreboard", 32'(o_out_sample), 32'(sb_exp));
            end
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!o_sample_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_ready: o_sample_ready stayed 0 for %0d cycles, required 1", n);
      end
   endtask

   // Accept one sample, check the issue cycle, and return on the first o_out_valid cycle
   task automatic issue_sample(input logic [15:0] x, input int unsigned k,
                               input logic [15:0] ey1, input logic [15:0] ey2,
                               input logic [15:0] eout, input int unsigned elat, input bit flush);
      int cyc;
      wait_ready();
      flt_delay      = k;
      i_sample_valid = 1'b1;
      i_sample       = x;
      i_flush        = flush;
      exp_q.push_back(eout);
      @(posedge clk); #1;
      i_sample_valid = 1'b0;
      i_flush        = 1'b0;
      check("issue_valid", 32'(o_flt_valid), 32'd1);
      check("issue_x", 32'(o_flt_x), 32'(x));
      check("issue_y1", 32'(o_flt_y1), 32'(ey1));
      check("issue_y2", 32'(o_flt_y2), 32'(ey2));
      cyc = 1;
      while (!o_out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 2) check("issue_pulse", 32'(o_flt_valid), 32'd0);
      end
      check("latency", 32'(cyc), 32'(elat));
   endtask

   task automatic finish_output();
      i_out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      int  seen;
      i_rst          = 1'b1;
      i_sample_valid = 1'b0;
      i_sample       = '0;
      i_out_ready    = 1'b1;
      i_coef_we      = 1'b0;
      i_coef_addr    = '0;
      i_coef_data    = '0;
      i_coef_commit  = 1'b0;
      i_flush        = 1'b0;

      vecs[0] = '{16'd1000,      1,  16'd0,         16'd0};
      vecs[1] = '{16'(-2000),    2,  16'd1000,      16'd0};
      vecs[2] = '{16'd300,       1,  16'(-2000),    16'd1000};
      vecs[3] = '{16'd32767,     3,  16'd300,       16'(-2000)};
      vecs[4] = '{16'(-32768),   16, 16'd32767,     16'd300};
      vecs[5] = '{16'd0,         1,  16'(-32768),   16'd32767};

      repeat (3) @(posedge clk);
      #1;
      i_rst = 1'b0;

      check("rst_ready", 32'(o_sample_ready), 32'd1);
      check("rst_flt_valid", 32'(o_flt_valid), 32'd0);
      check("rst_out_valid", 32'(o_out_valid), 32'd0);
      check("rst_out_sample", 32'(o_out_sample), 32'd0);
      check("rst_timeout", 32'(o_timeout), 32'd0);
      check("rst_cnt", 32'(o_sample_cnt), 32'd0);
      check("rst_b1", 32'(o_b1), 32'd65536);
      check("rst_b2", 32'(o_b2), 32'd0);
      check("rst_shift", 32'(o_shift), 32'd16);

      // Passthrough table, including the last-chance response at k=16
      for (int i = 0; i < 6; i++) begin
         issue_sample(vecs[i].x, vecs[i].k, vecs[i].ey1, vecs[i].ey2, vecs[i].x, vecs[i].k + 2, 1'b0);
         finish_output();
         check("sample_cnt", 32'(o_sample_cnt), 32'(i + 1));
      end

      // Backpressure: output held while downstream stalls
      i_out_ready = 1'b0;
      issue_sample(16'd1234, 3, 16'd0, 16'h8000, 16'd1234, 5, 1'b0);
      for (int i = 0; i < 10; i++) begin
         check("hold_valid", 32'(o_out_valid), 32'd1);
         check("hold_sample", 32'(o_out_sample), 32'd1234);
         check("hold_ready", 32'(o_sample_ready), 32'd0);
         check("hold_cnt", 32'(o_sample_cnt), 32'd6);
         @(posedge clk); #1;
      end
      finish_output();
      check("bp_cnt", 32'(o_sample_cnt), 32'd7);

      // Timeout: no response, zero output, history untouched
      flt_silent = 1'b1;
      issue_sample(16'd555, 1, 16'd1234, 16'd0, 16'd0, 18, 1'b0);
      check("to_sample", 32'(o_out_sample), 32'd0);
      check("to_flag", 32'(o_timeout), 32'd1);
      finish_output();
      flt_silent = 1'b0;
      issue_sample(16'd777, 2, 16'd1234, 16'd0, 16'd777, 4, 1'b0);
      finish_output();
      check("to_sticky", 32'(o_timeout), 32'd1);
      check("to_cnt", 32'(o_sample_cnt), 32'd9);

      // Commit during WAIT is deferred until IDLE
      wait_ready();
      flt_delay      = 4;
      i_sample_valid = 1'b1;
      i_sample       = 16'd42;
      exp_q.push_back(16'd42);
      @(posedge clk); #1;
      i_sample_valid = 1'b0;
      @(posedge clk); #1;
      i_coef_we     = 1'b1;
      i_coef_addr   = 3'd0;
      i_coef_data   = 18'd32768;
      i_coef_commit = 1'b1;
      @(posedge clk); #1;
      i_coef_we     = 1'b0;
      i_coef_commit = 1'b0;
      check("b1_wait", 32'(o_b1), 32'd65536);
      seen = 0;
      while (!o_out_valid && seen < 40) begin
         @(posedge clk); #1;
         seen++;
      end
      check("b1_output", 32'(o_b1), 32'd65536);
      finish_output();
      check("b1_idle", 32'(o_b1), 32'd65536);
      @(posedge clk); #1;
      check("b1_applied", 32'(o_b1), 32'd32768);

      // Address 6 ignored; write+commit in the same IDLE cycle applies
      i_coef_we     = 1'b1;
      i_coef_addr   = 3'd6;
      i_coef_data   = 18'h12345;
      i_coef_commit = 1'b1;
      @(posedge clk); #1;
      i_coef_we     = 1'b0;
      i_coef_commit = 1'b0;
      @(posedge clk); #1;
      check("a6_b1", 32'(o_b1), 32'd32768);
      check("a6_b2", 32'(o_b2), 32'd0);
      check("a6_b3", 32'(o_b3), 32'd0);
      check("a6_a2", 32'(o_a2), 32'd0);
      check("a6_a3", 32'(o_a3), 32'd0);
      check("a6_shift", 32'(o_shift), 32'd16);
      i_coef_we     = 1'b1;
      i_coef_addr   = 3'd1;
      i_coef_data   = 18'h3FFFB;
      i_coef_commit = 1'b1;
      @(posedge clk); #1;
      i_coef_addr   = 3'd5;
      i_coef_data   = 18'h3FF87;
      @(posedge clk); #1;
      i_coef_we     = 1'b0;
      i_coef_commit = 1'b0;
      check("wc_b2", 32'(o_b2), 32'h3FFFB);
      check("wc_shift", 32'(o_shift), 32'd7);

      // Flush with the accepting sample, then a flush deferred from OUTPUT
      issue_sample(16'd400, 1, 16'd42, 16'd777, 16'd400, 3, 1'b0);
      finish_output();
      issue_sample(16'd500, 1, 16'd400, 16'd42, 16'd500, 3, 1'b0);
      finish_output();
      issue_sample(16'd77, 1, 16'd0, 16'd0, 16'd77, 3, 1'b1);
      finish_output();
      i_out_ready = 1'b0;
      issue_sample(16'd88, 1, 16'd77, 16'd0, 16'd88, 3, 1'b0);
      i_flush = 1'b1;
      @(posedge clk); #1;
      i_flush = 1'b0;
      check("fl_still_out", 32'(o_out_valid), 32'd1);
      finish_output();
      issue_sample(16'd99, 1, 16'd0, 16'd0, 16'd99, 3, 1'b0);
      finish_output();
      check("fl_cnt", 32'(o_sample_cnt), 32'd15);

      // Counter wrap
      force dut.r_sample_cnt = 16'hFFFF;
      @(posedge clk); #1;
      release dut.r_sample_cnt;
      check("wrap_pre", 32'(o_sample_cnt), 32'hFFFF);
      issue_sample(16'd5, 1, 16'd99, 16'd0, 16'd5, 3, 1'b0);
      finish_output();
      check("wrap_cnt", 32'(o_sample_cnt), 32'd0);

      // Reset mid-WAIT aborts the sample with no output
      flt_silent = 1'b1;
      wait_ready();
      i_sample_valid = 1'b1;
      i_sample       = 16'd123;
      @(posedge clk); #1;
      i_sample_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      i_rst = 1'b1;
      @(posedge clk); #1;
      i_rst = 1'b0;
      check("mr_ready", 32'(o_sample_ready), 32'd1);
      check("mr_flt_valid", 32'(o_flt_valid), 32'd0);
      check("mr_flt_x", 32'(o_flt_x), 32'd0);
      check("mr_flt_y1", 32'(o_flt_y1), 32'd0);
      check("mr_flt_y2", 32'(o_flt_y2), 32'd0);
      check("mr_out_valid", 32'(o_out_valid), 32'd0);
      check("mr_out_sample", 32'(o_out_sample), 32'd0);
      check("mr_cnt", 32'(o_sample_cnt), 32'd0);
      check("mr_timeout", 32'(o_timeout), 32'd0);
      check("mr_b1", 32'(o_b1), 32'd65536);
      check("mr_b2", 32'(o_b2), 32'd0);
      check("mr_shift", 32'(o_shift), 32'd16);
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (o_out_valid) seen++;
      end
      check("mr_no_output", 32'(seen), 32'd0);
      flt_silent = 1'b0;

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
